// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: colour bars, checkerboard, grid and a
// bouncing box, re-timed so RGB and sync leave together at latency 2.
//
// Ports:
//   clk, reset            pixel clock, async active-high reset
//   hsync_in, vsync_in    sync from the timing generator
//   display_on            visible-area flag aligned with hpos/vpos
//   hpos, vpos            current pixel / line position (10 bits)
//   mode_next             one-cycle request to step to the next pattern
//   VGA_HS, VGA_VS        sync delayed by two cycles
//   VGA_R, VGA_G, VGA_B   registered 4-bit colour
//   mode                  active pattern (0 bars, 1 checker, 2 grid, 3 box)
//   frame_cnt             8-bit wrapping frame counter
module vga_pattern_gen #(
    parameter int   H_ACTIVE  = 640,
    parameter int   V_ACTIVE  = 480,
    parameter int   BOX       = 32,
    parameter logic SYNC_IDLE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       display_on,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       mode_next,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B,
    output logic [1:0] mode,
    output logic [7:0] frame_cnt
);

    localparam logic [1:0] MODE_BARS  = 2'd0;
    localparam logic [1:0] MODE_CHECK = 2'd1;
    localparam logic [1:0] MODE_GRID  = 2'd2;
    localparam logic [1:0] MODE_BOX   = 2'd3;

    localparam logic [9:0]  H_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  V_TICK = 10'(V_ACTIVE);
    localparam logic [9:0]  MAX_X  = 10'(H_ACTIVE - BOX);
    localparam logic [9:0]  MAX_Y  = 10'(V_ACTIVE - BOX);
    localparam logic [10:0] BOX_W  = 11'(BOX);

    // Sync delay line, two stages to match the colour pipeline.
    logic [1:0]  hs_q, hs_d;
    logic [1:0]  vs_q, vs_d;

    // Pixel pipeline.
    logic [11:0] color_q, color_d;
    logic        de_q, de_d;
    logic [11:0] rgb_q, rgb_d;

    // Frame-level state.
    logic [1:0]  mode_q, mode_d;
    logic        pending_q, pending_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [9:0]  box_x_q, box_x_d;
    logic [9:0]  box_y_q, box_y_d;
    logic        dir_x_q, dir_x_d;
    logic        dir_y_q, dir_y_d;

    logic        frame_tick;
    logic        advance;

    // Pattern helpers.
    logic [2:0]  bar_col;
    logic [2:0]  bar_idx;
    logic        checker_on;
    logic        grid_on;
    logic        in_box;

    // Returns {dir, pos} after one step of a bouncing axis.
    function automatic logic [10:0] bounce(
        input logic [9:0] pos,
        input logic       dir,
        input logic [9:0] max_pos
    );
        logic [10:0] r;
        if (dir && (pos >= max_pos)) begin
            r = {1'b0, pos - 10'd2};
        end else if (!dir && (pos == 10'd0)) begin
            r = {1'b1, 10'd2};
        end else if (dir) begin
            r = {1'b1, pos + 10'd2};
        end else begin
            r = {1'b0, pos - 10'd2};
        end
        return r;
    endfunction

    // The first pixel of the first blanking line marks the frame boundary,
    // independent of sync polarity.
    assign frame_tick = (hpos == 10'd0) && (vpos == V_TICK);
    assign advance    = frame_tick && (pending_q || mode_next);

    always_comb begin
        hs_d = {hs_q[0], hsync_in};
        vs_d = {vs_q[0], vsync_in};
    end

    always_comb begin
        mode_d      = mode_q;
        pending_d   = pending_q;
        frame_cnt_d = frame_cnt_q;
        {dir_x_d, box_x_d} = {dir_x_q, box_x_q};
        {dir_y_d, box_y_d} = {dir_y_q, box_y_q};

        if (frame_tick) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            {dir_x_d, box_x_d} = bounce(box_x_q, dir_x_q, MAX_X);
            {dir_y_d, box_y_d} = bounce(box_y_q, dir_y_q, MAX_Y);
            // A request landing on the tick itself is consumed here.
            pending_d = 1'b0;
            if (advance) begin
                mode_d = mode_q + 2'd1;
            end
        end else if (mode_next) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        // Column index equals hpos/80, saturating at 7 past the last bar.
        bar_col = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (hpos >= 10'(i * 80)) begin
                bar_col = 3'(i);
            end
        end
        bar_idx = 3'd7 - bar_col;

        checker_on = hpos[5] ^ vpos[5];

        grid_on = ((hpos % 10'd80) == 10'd0)
               || ((vpos % 10'd60) == 10'd0)
               || (hpos == H_LAST)
               || (vpos == V_LAST);

        // Widened so box + BOX cannot wrap near the right/bottom edge.
        in_box = ({1'b0, hpos} >= {1'b0, box_x_q})
              && ({1'b0, hpos} <  ({1'b0, box_x_q} + BOX_W))
              && ({1'b0, vpos} >= {1'b0, box_y_q})
              && ({1'b0, vpos} <  ({1'b0, box_y_q} + BOX_W));

        color_d = 12'h000;
        unique case (mode_q)
            MODE_BARS: begin
                color_d = {{4{bar_idx[2]}},
                           {4{bar_idx[1]}},
                           {4{bar_idx[0]}}};
            end
            MODE_CHECK: begin
                color_d = checker_on ? 12'hFFF : 12'h000;
            end
            MODE_GRID: begin
                color_d = grid_on ? 12'hFFF : 12'h003;
            end
            MODE_BOX: begin
                color_d = in_box ? 12'hF00 : 12'h000;
            end
            default: begin
                color_d = 12'h000;
            end
        endcase

        de_d  = display_on;
        rgb_d = de_q ? color_q : 12'h000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_q        <= {2{SYNC_IDLE}};
            vs_q        <= {2{SYNC_IDLE}};
            color_q     <= 12'h000;
            de_q        <= 1'b0;
            rgb_q       <= 12'h000;
            mode_q      <= MODE_BARS;
            pending_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
            box_x_q     <= 10'd0;
            box_y_q     <= 10'd0;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
        end else begin
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            color_q     <= color_d;
            de_q        <= de_d;
            rgb_q       <= rgb_d;
            mode_q      <= mode_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
            box_x_q     <= box_x_d;
            box_y_q     <= box_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
        end
    end

    assign VGA_HS    = hs_q[1];
    assign VGA_VS    = vs_q[1];
    assign VGA_R     = rgb_q[11:8];
    assign VGA_G     = rgb_q[7:4];
    assign VGA_B     = rgb_q[3:0];
    assign mode      = mode_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed self-checking bench for vga_pattern_gen.
// Outputs are sampled 1 time unit after the rising edge.
module tb_vga_pattern_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync_in;
    logic       vsync_in;
    logic       display_on;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       mode_next;
    logic       VGA_HS;
    logic       VGA_VS;
    logic [3:0] VGA_R;
    logic [3:0] VGA_G;
    logic [3:0] VGA_B;
    logic [1:0] mode;
    logic [7:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_pattern_gen dut (
        .clk        (clk),
        .reset      (reset),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .display_on (display_on),
        .hpos       (hpos),
        .vpos       (vpos),
        .mode_next  (mode_next),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .mode       (mode),
        .frame_cnt  (frame_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hpos       = 10'd100;
        vpos       = 10'd100;
        display_on = 1'b0;
        mode_next  = 1'b0;
        hsync_in   = 1'b1;
        vsync_in   = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // One-cycle frame boundary, then one blanking pixel.
    task automatic tick(input logic mn);
        hpos       = 10'd0;
        vpos       = 10'd480;
        display_on = 1'b0;
        mode_next  = mn;
        step();
        hpos      = 10'd1;
        mode_next = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h000) begin
            errors++;
            $display("FAIL reset_rgb got %h want 000", {VGA_R, VGA_G, VGA_B});
        end
        checks++;
        if ({VGA_HS, VGA_VS} !== 2'b11) begin
            errors++;
            $display("FAIL reset_sync got %b want 11", {VGA_HS, VGA_VS});
        end
        checks++;
        if (mode !== 2'd0 || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state mode %0d cnt %0d want 0 0", mode, frame_cnt);
        end
        checks++;
        if ({dut.dir_x_q, dut.dir_y_q, dut.box_x_q, dut.box_y_q} !== {2'b11, 20'd0}) begin
            errors++;
            $display("FAIL reset_box x %0d y %0d dx %b dy %b want 0 0 1 1",
                     dut.box_x_q, dut.box_y_q, dut.dir_x_q, dut.dir_y_q);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_bars();
        do_reset();
        display_on = 1'b1;
        vpos = 10'd10;
        hpos = 10'd0;
        step();
        hpos = 10'd80;
        step();
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'hFFF) begin
            errors++;
            $display("FAIL bars_h0 got %h want FFF", {VGA_R, VGA_G, VGA_B});
        end
        hpos = 10'd400;
        step();
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'hFF0) begin
            errors++;
            $display("FAIL bars_h80 got %h want FF0", {VGA_R, VGA_G, VGA_B});
        end
        hpos = 10'd639;
        step();
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h0F0) begin
            errors++;
            $display("FAIL bars_h400 got %h want 0F0", {VGA_R, VGA_G, VGA_B});
        end
        display_on = 1'b0;
        hpos = 10'd0;
        step();
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h000) begin
            errors++;
            $display("FAIL bars_h639 got %h want 000", {VGA_R, VGA_G, VGA_B});
        end
        step();
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h000) begin
            errors++;
            $display("FAIL blank_rgb got %h want 000", {VGA_R, VGA_G, VGA_B});
        end
    endtask

    task automatic test_sync();
        idle_inputs();
        step();
        step();
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        step();
        checks++;
        if ({VGA_HS, VGA_VS} !== 2'b11) begin
            errors++;
            $display("FAIL sync_lat1 got %b want 11", {VGA_HS, VGA_VS});
        end
        hsync_in = 1'b1;
        step();
        checks++;
        if ({VGA_HS, VGA_VS} !== 2'b00) begin
            errors++;
            $display("FAIL sync_lat2 got %b want 00", {VGA_HS, VGA_VS});
        end
        step();
        checks++;
        if (VGA_HS !== 1'b1) begin
            errors++;
            $display("FAIL sync_rise got %b want 1", VGA_HS);
        end
    endtask

    task automatic test_checker();
        do_reset();
        tick(1'b1);
        checks++;
        if (mode !== 2'd1) begin
            errors++;
            $display("FAIL chk_mode got %0d want 1", mode);
        end
        display_on = 1'b1;
        hpos = 10'd32;
        vpos = 10'd0;
        step();
        vpos = 10'd32;
        step();
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'hFFF) begin
            errors++;
            $display("FAIL chk_32_0 got %h want FFF", {VGA_R, VGA_G, VGA_B});
        end
        hpos = 10'd0;
        vpos = 10'd0;
        step();
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h000) begin
            errors++;
            $display("FAIL chk_32_32 got %h want 000", {VGA_R, VGA_G, VGA_B});
        end
    endtask

    task automatic test_mode_next();
        do_reset();
        hpos = 10'd5;
        vpos = 10'd5;
        mode_next = 1'b1;
        step();
        mode_next = 1'b0;
        step();
        checks++;
        if (mode !== 2'd0 || dut.pending_q !== 1'b1) begin
            errors++;
            $display("FAIL mn_hold mode %0d pend %b want 0 1", mode, dut.pending_q);
        end
        tick(1'b0);
        checks++;
        if (mode !== 2'd1 || dut.pending_q !== 1'b0) begin
            errors++;
            $display("FAIL mn_apply mode %0d pend %b want 1 0", mode, dut.pending_q);
        end
        for (int i = 0; i < 3; i++) begin
            hpos = 10'd20;
            vpos = 10'd20;
            mode_next = 1'b1;
            step();
            mode_next = 1'b0;
            step();
        end
        checks++;
        if (mode !== 2'd1) begin
            errors++;
            $display("FAIL mn_multi_hold got %0d want 1", mode);
        end
        tick(1'b0);
        checks++;
        if (mode !== 2'd2) begin
            errors++;
            $display("FAIL mn_multi got %0d want 2", mode);
        end
        tick(1'b0);
        checks++;
        if (mode !== 2'd2) begin
            errors++;
            $display("FAIL mn_idle_tick got %0d want 2", mode);
        end
    endtask

    // Runs in mode 2, left by test_mode_next.
    task automatic test_grid();
        logic [9:0]  hv [6];
        logic [9:0]  vv [6];
        logic [11:0] ev [6];
        hv = '{10'd80, 10'd81, 10'd81, 10'd639, 10'd300, 10'd0};
        vv = '{10'd7,  10'd7,  10'd60, 10'd7,   10'd479, 10'd1};
        ev = '{12'hFFF, 12'h003, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        display_on = 1'b1;
        for (int i = 0; i < 6; i++) begin
            hpos = hv[i];
            vpos = vv[i];
            step();
            step();
            checks++;
            if ({VGA_R, VGA_G, VGA_B} !== ev[i]) begin
                errors++;
                $display("FAIL grid_%0d_%0d got %h want %h",
                         hv[i], vv[i], {VGA_R, VGA_G, VGA_B}, ev[i]);
            end
        end
    endtask

    task automatic test_box();
        logic [9:0]  hv [5];
        logic [9:0]  vv [5];
        logic [11:0] ev [5];
        hv = '{10'd6, 10'd37, 10'd38, 10'd5, 10'd6};
        vv = '{10'd6, 10'd37, 10'd6,  10'd6, 10'd38};
        ev = '{12'hF00, 12'hF00, 12'h000, 12'h000, 12'h000};
        do_reset();
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        checks++;
        if (mode !== 2'd3 || dut.box_x_q !== 10'd6 || dut.box_y_q !== 10'd6) begin
            errors++;
            $display("FAIL box_setup mode %0d x %0d y %0d want 3 6 6",
                     mode, dut.box_x_q, dut.box_y_q);
        end
        display_on = 1'b1;
        for (int i = 0; i < 5; i++) begin
            hpos = hv[i];
            vpos = vv[i];
            step();
            step();
            checks++;
            if ({VGA_R, VGA_G, VGA_B} !== ev[i]) begin
                errors++;
                $display("FAIL box_%0d_%0d got %h want %h",
                         hv[i], vv[i], {VGA_R, VGA_G, VGA_B}, ev[i]);
            end
        end
        tick(1'b1);
        checks++;
        if (mode !== 2'd0 || dut.pending_q !== 1'b0) begin
            errors++;
            $display("FAIL wrap_3_0 mode %0d pend %b want 0 0", mode, dut.pending_q);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int i = 1; i <= 305; i++) begin
            tick(1'b0);
            if (i == 224) begin
                checks++;
                if (dut.box_y_q !== 10'd448 || dut.dir_y_q !== 1'b1) begin
                    errors++;
                    $display("FAIL by_224 got %0d/%b want 448/1", dut.box_y_q, dut.dir_y_q);
                end
            end
            if (i == 225) begin
                checks++;
                if (dut.box_y_q !== 10'd446 || dut.dir_y_q !== 1'b0) begin
                    errors++;
                    $display("FAIL by_225 got %0d/%b want 446/0", dut.box_y_q, dut.dir_y_q);
                end
            end
            if (i == 304) begin
                checks++;
                if (dut.box_x_q !== 10'd608 || dut.dir_x_q !== 1'b1) begin
                    errors++;
                    $display("FAIL bx_304 got %0d/%b want 608/1", dut.box_x_q, dut.dir_x_q);
                end
                checks++;
                if (dut.box_y_q !== 10'd288) begin
                    errors++;
                    $display("FAIL by_304 got %0d want 288", dut.box_y_q);
                end
            end
        end
        checks++;
        if (dut.box_x_q !== 10'd606 || dut.dir_x_q !== 1'b0) begin
            errors++;
            $display("FAIL bx_305 got %0d/%b want 606/0", dut.box_x_q, dut.dir_x_q);
        end
        checks++;
        if (frame_cnt !== 8'd49) begin
            errors++;
            $display("FAIL fcnt_wrap got %0d want 49", frame_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            tick((i == 1 || i == 2) ? 1'b1 : 1'b0);
        end
        checks++;
        if (mode !== 2'd2 || frame_cnt !== 8'd17) begin
            errors++;
            $display("FAIL mid_setup mode %0d cnt %0d want 2 17", mode, frame_cnt);
        end
        display_on = 1'b1;
        hpos = 10'd80;
        vpos = 10'd7;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        step();
        step();
        checks++;
        if ({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS} !== {12'hFFF, 2'b00}) begin
            errors++;
            $display("FAIL mid_pre rgb %h sync %b want FFF 00",
                     {VGA_R, VGA_G, VGA_B}, {VGA_HS, VGA_VS});
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h000 || {VGA_HS, VGA_VS} !== 2'b11) begin
            errors++;
            $display("FAIL mid_async rgb %h sync %b want 000 11",
                     {VGA_R, VGA_G, VGA_B}, {VGA_HS, VGA_VS});
        end
        checks++;
        if (mode !== 2'd0 || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mid_async_st mode %0d cnt %0d want 0 0", mode, frame_cnt);
        end
        reset = 1'b0;
        step();
        checks++;
        if (frame_cnt !== 8'd0 || mode !== 2'd0) begin
            errors++;
            $display("FAIL mid_release cnt %0d mode %0d want 0 0", frame_cnt, mode);
        end
        tick(1'b0);
        checks++;
        if (frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL mid_resume got %0d want 1", frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_bars();
        test_sync();
        test_checker();
        test_mode_next();
        test_grid();
        test_box();
        test_bounce();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
